mem_stage_sb: RTL and testbench
===============================

# mem_stage_sb

Parametrised memory-access pipeline stage for the ARM core. It sits between EX and WB, like the single-cycle MEM stage, but talks to a multi-cycle external data memory over a req/ready handshake. Stores are absorbed into a store buffer of depth `SB_DEPTH` and drained in the background. Loads are forwarded from that buffer or fetched from memory, and the stage raises `freeze_out` to stall upstream stages whenever an access cannot complete.

## Interface
Parameters:
- `DATA_W`, 32, data word width
- `ADDR_W`, 32, address width; byte address, word-aligned (bits [1:0] ignored)
- `REG_W`, 4, destination register index width
- `SB_DEPTH`, 4, store-buffer entries; power of 2, ≥2

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk` in 1: clock
- `rst` in 1: synchronous active-high reset
- `wb_en_in` in 1: instruction writes back
- `mem_r_en_in` in 1: load
- `mem_w_en_in` in 1: store; never high together with `mem_r_en_in`
- `dest_in` in REG_W: destination register
- `alu_res_in` in ADDR_W: address or ALU result
- `val_rm` in DATA_W: store data
- `freeze_out` out 1: stall request; combinational
- `wb_en_out` out 1: registered to WB
- `mem_r_en_out` out 1: registered to WB
- `dest_out` out REG_W: registered to WB
- `alu_res_out` out ADDR_W: registered to WB
- `data_mem_out` out DATA_W: registered load data; 0 for non-loads
- `sb_empty` out 1: store buffer empty
- `mem_req` out 1: memory request
- `mem_we` out 1: 1 = write, 0 = read
- `mem_addr` out ADDR_W: memory address
- `mem_wdata` out DATA_W: memory write data
- `mem_ready` in 1: memory completes the request this cycle
- `mem_rdata` in DATA_W: read data, valid when `mem_ready`=1 and `mem_we`=0

## Operation
- **Store buffer:** FIFO of {word address, data}. Head is the oldest entry. An entry is removed only when its write completes.
- **Non-memory instruction:** passes through in one cycle. `freeze_out`=0, regardless of buffer or FSM state.
- **Store:**
  - Enqueued in its cycle if the buffer is not full, or if a drain completes that same cycle (`mem_ready` in DRAIN).
  - Otherwise `freeze_out`=1.
- **Load:**
  - Word address is compared against all valid buffer entries, including the one being drained.
  - Hit: the youngest matching entry's data is forwarded, with no stall.
  - Miss: `freeze_out`=1 until the read completes.
- **FSM: IDLE, DRAIN, LOAD.**
  - IDLE → LOAD when a load miss is present; this has priority over draining.
  - IDLE → DRAIN when the buffer is non-empty and there is no load miss.
  - DRAIN: `mem_req`=1, `mem_we`=1, addr/data from head. On `mem_ready`: pop head, → IDLE.
  - LOAD: `mem_req`=1, `mem_we`=0, `mem_addr`=`alu_res_in`. On `mem_ready`: capture `mem_rdata`, clear `freeze_out` that cycle, → IDLE.
  - A load miss arriving during DRAIN waits for the drain to finish, then passes through IDLE to LOAD.
- **Handshake:** `mem_addr`/`mem_we`/`mem_wdata` are stable while `mem_req`=1 and until `mem_ready` is sampled high. `mem_req`=0 in IDLE.
- **Upstream contract:** upstream holds all `*_in` stable while `freeze_out`=1.
- **Bubbles:** each cycle with `freeze_out`=1 loads a bubble into the output register: `wb_en_out`=0, `mem_r_en_out`=0, `data_mem_out`=0.
- **Flush:** `sb_empty` lets control logic wait for the buffer to drain, e.g. before SWI or halt.

## Timing
- **Reset:** all registered outputs 0, `mem_req`=0, `sb_empty`=1, FSM=IDLE, buffer cleared. Pending stores are discarded. Reset overrides an in-flight request; `mem_req` is 0 in the cycle after reset.
- **Pass-through and load hit:** latency 1 cycle.
- **Store:** 1 cycle when not full.
- **Load miss from IDLE, load in stage at cycle 0:**
  - Cycle 1: FSM=LOAD, `mem_req`=1.
  - `mem_ready` at cycle k≥1: `freeze_out` low at k, outputs valid at k+1.
  - Minimum stall is 1 cycle.
- **Drain gap:** one IDLE cycle between consecutive transactions.
- **Simultaneous enqueue and pop:** count unchanged.
- **Full and empty:** exact via a count of width log2(SB_DEPTH)+1; pointers wrap modulo SB_DEPTH.

## Test plan
- **Reset:** after reset, all outputs 0, `sb_empty`=1, `mem_req`=0 with `mem_ready`=0.
- **Store then load, forwarded:** store 0x100←0xDEADBEEF, next cycle load 0x100 with `mem_ready`=0. Next cycle `data_mem_out`=0xDEADBEEF, `freeze_out` never 1, no read request.
- **Youngest match:** stores 0x40←1 then 0x40←2, then load 0x40 → `data_mem_out`=2.
- **Buffer full:** `SB_DEPTH`=4, `mem_ready`=0, five stores → `freeze_out`=1 on the fifth. Pulse `mem_ready` → fifth accepted that cycle. Memory then observes writes in program order.
- **Load miss during drain:** load 0x200 arrives during DRAIN; `mem_rdata`=0x1234 with a 3-cycle ready delay. Drain completes first, then the read. `data_mem_out`=0x1234 one cycle after ready, with bubbles while frozen.
- **Reset mid-LOAD:** `rst` asserted while `mem_req`=1 → next cycle `mem_req`=0, FSM=IDLE, `sb_empty`=1, outputs 0.

Source files
------------

// File: rtl/mem_stage_sb.sv
// MEM pipeline stage with a store buffer in front of a multi-cycle req/ready
// data memory. Stores drain in the background; loads forward from the buffer or stall.
module mem_stage_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int REG_W    = 4,
   parameter int SB_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_en_in,
   input  logic              mem_r_en_in,
   input  logic              mem_w_en_in,
   input  logic [REG_W-1:0]  dest_in,
   input  logic [ADDR_W-1:0] alu_res_in,
   input  logic [DATA_W-1:0] val_rm,
   output logic              freeze_out,
   output logic              wb_en_out,
   output logic              mem_r_en_out,
   output logic [REG_W-1:0]  dest_out,
   output logic [ADDR_W-1:0] alu_res_out,
   output logic [DATA_W-1:0] data_mem_out,
   output logic              sb_empty,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int PTR_W = $clog2(SB_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WA_W  = ADDR_W - 2;

   typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, LOAD = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [WA_W-1:0]   sb_addr_q [SB_DEPTH];
   logic [DATA_W-1:0] sb_data_q [SB_DEPTH];

   logic [WA_W-1:0]     addr_word;
   logic [SB_DEPTH-1:0] match_vec;
   logic                hit;
   logic [DATA_W-1:0]   fwd_data;
   logic [PTR_W-1:0]    fwd_idx;
   logic                sb_full, drain_done, load_done, load_miss, enq, freeze;

   logic              wb_en_q, wb_en_d, mem_r_en_q, mem_r_en_d;
   logic [REG_W-1:0]  dest_q, dest_d;
   logic [ADDR_W-1:0] alu_res_q, alu_res_d;
   logic [DATA_W-1:0] data_mem_q, data_mem_d;
   logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   assign addr_word = alu_res_in[ADDR_W-1:2];

   for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_match
      assign match_vec[gi] = (sb_addr_q[gi] == addr_word);
   end

   // Walk oldest to youngest so the last valid match (youngest) wins.
   always_comb begin
      hit      = 1'b0;
      fwd_data = '0;
      fwd_idx  = head_q;
      for (int k = 0; k < SB_DEPTH; k++) begin
         fwd_idx = head_q + PTR_W'(k);
         if ((CNT_W'(k) < count_q) && match_vec[fwd_idx]) begin
            hit      = 1'b1;
            fwd_data = sb_data_q[fwd_idx];
         end
      end
   end

   assign sb_full    = (count_q == CNT_W'(SB_DEPTH));
   assign drain_done = (state_q == DRAIN) && mem_ready;
   assign load_done  = (state_q == LOAD) && mem_ready;
   assign load_miss  = mem_r_en_in && !hit;
   assign enq        = mem_w_en_in && (!sb_full || drain_done);
   assign freeze     = (mem_w_en_in && !enq) || (load_miss && !load_done);

   always_comb begin
      head_d  = drain_done ? head_q + 1'b1 : head_q;
      tail_d  = enq ? tail_q + 1'b1 : tail_q;
      count_d = count_q + CNT_W'(enq) - CNT_W'(drain_done);

      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (load_miss)
               state_d = LOAD;
            else if (count_q != '0)
               state_d = DRAIN;
         end
         DRAIN:   if (mem_ready) state_d = IDLE;
         LOAD:    if (mem_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Handshake fields are latched on leaving IDLE and held until completion.
      mem_req_d   = (state_d != IDLE);
      mem_we_d    = (state_d == DRAIN);
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (state_d == IDLE) begin
         mem_addr_d  = '0;
         mem_wdata_d = '0;
      end else if (state_q == IDLE) begin
         if (state_d == DRAIN) begin
            mem_addr_d  = {sb_addr_q[head_q], 2'b00};
            mem_wdata_d = sb_data_q[head_q];
         end else begin
            mem_addr_d  = alu_res_in;
            mem_wdata_d = '0;
         end
      end

      wb_en_d    = freeze ? 1'b0 : wb_en_in;
      mem_r_en_d = freeze ? 1'b0 : mem_r_en_in;
      dest_d     = dest_in;
      alu_res_d  = alu_res_in;
      data_mem_d = '0;
      if (!freeze && mem_r_en_in)
         data_mem_d = hit ? fwd_data : mem_rdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         wb_en_q     <= 1'b0;
         mem_r_en_q  <= 1'b0;
         dest_q      <= '0;
         alu_res_q   <= '0;
         data_mem_q  <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         wb_en_q     <= wb_en_d;
         mem_r_en_q  <= mem_r_en_d;
         dest_q      <= dest_d;
         alu_res_q   <= alu_res_d;
         data_mem_q  <= data_mem_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Entry storage needs no reset: validity is tracked by head/count alone.
   always_ff @(posedge clk) begin
      if (enq) begin
         sb_addr_q[tail_q] <= addr_word;
         sb_data_q[tail_q] <= val_rm;
      end
   end

   assign freeze_out   = freeze;
   assign wb_en_out    = wb_en_q;
   assign mem_r_en_out = mem_r_en_q;
   assign dest_out     = dest_q;
   assign alu_res_out  = alu_res_q;
   assign data_mem_out = data_mem_q;
   assign sb_empty     = (count_q == '0);
   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
endmodule

// File: tb/tb_mem_stage_sb.sv
// Bench for mem_stage_sb: scoreboards for memory writes and load results plus
// per-scenario tasks with inline checks against a behavioural memory responder.
module tb_mem_stage_sb;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 32;
   localparam int REG_W    = 4;
   localparam int SB_DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0;
   logic [REG_W-1:0]  dest_in = '0;
   logic [ADDR_W-1:0] alu_res_in = '0;
   logic [DATA_W-1:0] val_rm = '0;
   logic              freeze_out, wb_en_out, mem_r_en_out, sb_empty;
   logic [REG_W-1:0]  dest_out;
   logic [ADDR_W-1:0] alu_res_out, mem_addr;
   logic [DATA_W-1:0] data_mem_out, mem_wdata;
   logic              mem_req, mem_we;
   logic              mem_ready = 1'b0;
   logic [DATA_W-1:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_stage_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .SB_DEPTH(SB_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .dest_in(dest_in), .alu_res_in(alu_res_in), .val_rm(val_rm),
      .freeze_out(freeze_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
      .dest_out(dest_out), .alu_res_out(alu_res_out), .data_mem_out(data_mem_out),
      .sb_empty(sb_empty), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0]        exp_load_q[$];
   logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];

   bit auto_en      = 1'b0;
   bit manual_ready = 1'b0;
   int delay        = 1;
   int wait_cnt     = 0;

   // Memory responder: in auto mode raises ready in the delay-th cycle of a request.
   always @(posedge clk) begin
      #2;
      if (!auto_en) begin
         mem_ready = manual_ready;
         wait_cnt  = 0;
      end else if (mem_req && !mem_ready) begin
         wait_cnt++;
         if (wait_cnt >= delay) begin
            mem_ready = 1'b1;
            wait_cnt  = 0;
         end
      end else begin
         mem_ready = 1'b0;
         wait_cnt  = 0;
      end
   end

   always @(negedge clk) begin
      logic [ADDR_W+DATA_W-1:0] ew;
      logic [DATA_W-1:0]        el;
      if (!rst && mem_req && mem_we && mem_ready) begin
         $display("[%0t] mem write addr=%h data=%h", $time, mem_addr, mem_wdata);
         checks++;
         if (exp_wr_q.size() == 0) begin
            errors++;
            $display("FAIL wr_sb: unexpected write addr=%h data=%h", mem_addr, mem_wdata);
         end else begin
            ew = exp_wr_q.pop_front();
            if ({mem_addr, mem_wdata} !== ew) begin
               errors++;
               $display("FAIL wr_sb: got addr=%h data=%h expected addr=%h data=%h",
                        mem_addr, mem_wdata, ew[ADDR_W+DATA_W-1:DATA_W], ew[DATA_W-1:0]);
            end
         end
      end
      if (mem_r_en_out === 1'b1) begin
         $display("[%0t] load result dest=%0d data=%h", $time, dest_out, data_mem_out);
         checks++;
         if (exp_load_q.size() == 0) begin
            errors++;
            $display("FAIL load_sb: unexpected load result data=%h", data_mem_out);
         end else begin
            el = exp_load_q.pop_front();
            if (data_mem_out !== el) begin
               errors++;
               $display("FAIL load_sb: got data=%h expected %h", data_mem_out, el);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic wb, input logic rd, input logic wr, input logic [REG_W-1:0] d,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
      wb_en_in = wb; mem_r_en_in = rd; mem_w_en_in = wr;
      dest_in = d; alu_res_in = a; val_rm = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_empty(input int max_cycles);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sb_empty && n < max_cycles);
      checks++;
      if (sb_empty !== 1'b1) begin
         errors++;
         $display("FAIL drain_timeout: sb_empty=%b after %0d cycles, required 1", sb_empty, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(0, 0, 0, '0, '0, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({wb_en_out, mem_r_en_out, dest_out, alu_res_out, data_mem_out} !== '0) begin
         errors++;
         $display("FAIL reset_outs: wb=%b rd=%b dest=%h res=%h data=%h, required all 0",
                  wb_en_out, mem_r_en_out, dest_out, alu_res_out, data_mem_out);
      end
      checks++;
      if (sb_empty !== 1'b1 || mem_req !== 1'b0 || freeze_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: sb_empty=%b mem_req=%b freeze=%b, required 1 0 0",
                  sb_empty, mem_req, freeze_out);
      end
      checks++;
      if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
         errors++;
         $display("FAIL reset_mem: we=%b addr=%h wdata=%h, required 0", mem_we, mem_addr, mem_wdata);
      end
      step();
      rst = 1'b0;
   endtask

   task automatic test_passthrough();
      step();
      drive(1, 0, 0, 4'd5, 32'h1234_5678, 32'hFFFF_0000);
      @(negedge clk);
      checks++;
      if (freeze_out !== 1'b0) begin
         errors++;
         $display("FAIL pass_freeze: freeze=%b, required 0", freeze_out);
      end
      step();
      drive(0, 0, 0, 4'd9, 32'hCAFE_0001, '0);
      @(negedge clk);
      checks++;
      if (wb_en_out !== 1'b1 || mem_r_en_out !== 1'b0 || dest_out !== 4'd5 ||
          alu_res_out !== 32'h1234_5678 || data_mem_out !== '0) begin
         errors++;
         $display("FAIL pass_alu: wb=%b rd=%b dest=%h res=%h data=%h, required 1 0 5 12345678 0",
                  wb_en_out, mem_r_en_out, dest_out, alu_res_out, data_mem_out);
      end
      step();
      drive(0, 0, 0, '0, '0, '0);
      @(negedge clk);
      checks++;
      if (wb_en_out !== 1'b0 || dest_out !== 4'd9 || alu_res_out !== 32'hCAFE_0001) begin
         errors++;
         $display("FAIL pass_nowb: wb=%b dest=%h res=%h, required 0 9 cafe0001",
                  wb_en_out, dest_out, alu_res_out);
      end
   endtask

   task automatic test_store_forward();
      auto_en = 1'b0; manual_ready = 1'b0;
      step();
      drive(0, 0, 1, '0, 32'h100, 32'hDEAD_BEEF);
      exp_wr_q.push_back({32'h100, 32'hDEAD_BEEF});
      @(negedge clk);
      checks++;
      if (freeze_out !== 1'b0) begin
         errors++;
         $display("FAIL fwd_store_freeze: freeze=%b, required 0", freeze_out);
      end
      step();
      drive(1, 1, 0, 4'd3, 32'h100, '0);
      exp_load_q.push_back(32'hDEAD_BEEF);
      @(negedge clk);
      checks++;
      if (freeze_out !== 1'b0 || (mem_req === 1'b1 && mem_we === 1'b0)) begin
         errors++;
         $display("FAIL fwd_load: freeze=%b req=%b we=%b, required no freeze and no read",
                  freeze_out, mem_req, mem_we);
      end
      step();
      drive(0, 0, 0, '0, '0, '0);
      @(negedge clk);
      checks++;
      if (dest_out !== 4'd3 || (mem_req === 1'b1 && mem_we === 1'b0)) begin
         errors++;
         $display("FAIL fwd_result: dest=%h req=%b we=%b, required dest 3 and no read",
                  dest_out, mem_req, mem_we);
      end
      delay = 1; auto_en = 1'b1;
      wait_empty(40);
   endtask

   task automatic test_youngest();
      auto_en = 1'b0; manual_ready = 1'b0;
      step();
      drive(0, 0, 1, '0, 32'h40, 32'd1);
      exp_wr_q.push_back({32'h40, 32'd1});
      step();
      drive(0, 0, 1, '0, 32'h40, 32'd2);
      exp_wr_q.push_back({32'h40, 32'd2});
      step();
      drive(1, 1, 0, 4'd7, 32'h40, '0);
      exp_load_q.push_back(32'd2);
      @(negedge clk);
      checks++;
      if (freeze_out !== 1'b0) begin
         errors++;
         $display("FAIL young_freeze: freeze=%b, required 0", freeze_out);
      end
      step();
      drive(0, 0, 0, '0, '0, '0);
      @(negedge clk);
      delay = 1; auto_en = 1'b1;
      wait_empty(60);
   endtask

   task automatic test_buffer_full();
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] v;
      logic              exp_f;
      auto_en = 1'b0; manual_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         a = 32'h10 + 32'(4 * i);
         v = 32'(i + 1);
         drive(0, 0, 1, '0, a, v);
         exp_wr_q.push_back({a, v});
         exp_f = (i == 4);
         @(negedge clk);
         checks++;
         if (freeze_out !== exp_f) begin
            errors++;
            $display("FAIL full_store%0d: freeze=%b, required %b", i, freeze_out, exp_f);
         end
      end
      step();
      @(negedge clk);
      checks++;
      if (freeze_out !== 1'b1) begin
         errors++;
         $display("FAIL full_hold: freeze=%b, required 1", freeze_out);
      end
      step();
      manual_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (freeze_out !== 1'b0 || mem_req !== 1'b1 || mem_we !== 1'b1) begin
         errors++;
         $display("FAIL full_accept: freeze=%b req=%b we=%b, required 0 1 1", freeze_out, mem_req, mem_we);
      end
      step();
      manual_ready = 1'b0;
      drive(0, 0, 0, '0, '0, '0);
      @(negedge clk);
      checks++;
      if (sb_empty !== 1'b0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL full_gap: sb_empty=%b req=%b, required 0 0", sb_empty, mem_req);
      end
      delay = 2; auto_en = 1'b1;
      wait_empty(80);
   endtask

   task automatic test_back_to_back();
      int frozen = 0;
      bit done = 1'b0;
      delay = 1; auto_en = 1'b1;
      mem_rdata = 32'h5555_AAAA;
      step();
      drive(1, 1, 0, 4'd9, 32'h700, '0);
      exp_load_q.push_back(32'h5555_AAAA);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_req === 1'b1) begin
            checks++;
            if (mem_we !== 1'b0 || mem_addr !== 32'h700) begin
               errors++;
               $display("FAIL b2b_req: we=%b addr=%h, required 0 00000700", mem_we, mem_addr);
            end
         end
         if (freeze_out === 1'b0) begin
            done = 1'b1;
            break;
         end
         frozen++;
         step();
      end
      checks++;
      if (!done || frozen != 1) begin
         errors++;
         $display("FAIL b2b_stall: frozen cycles=%0d done=%b, required 1 cycle", frozen, done);
      end
      step();
      drive(1, 0, 0, 4'd2, 32'hABC, '0);
      @(negedge clk);
      checks++;
      if (freeze_out !== 1'b0) begin
         errors++;
         $display("FAIL b2b_alu_freeze: freeze=%b, required 0", freeze_out);
      end
      step();
      drive(0, 0, 0, '0, '0, '0);
      @(negedge clk);
      checks++;
      if (wb_en_out !== 1'b1 || dest_out !== 4'd2 || alu_res_out !== 32'hABC || data_mem_out !== '0) begin
         errors++;
         $display("FAIL b2b_alu: wb=%b dest=%h res=%h data=%h, required 1 2 abc 0",
                  wb_en_out, dest_out, alu_res_out, data_mem_out);
      end
   endtask

   task automatic test_load_miss_during_drain();
      int frozen = 0;
      int wr_done = -1;
      int rd_start = -1;
      bit done = 1'b0;
      delay = 3; auto_en = 1'b1;
      mem_rdata = 32'h1234;
      step();
      drive(0, 0, 1, '0, 32'h300, 32'hAAAA);
      exp_wr_q.push_back({32'h300, 32'hAAAA});
      step();
      drive(0, 0, 0, '0, '0, '0);
      step();
      drive(1, 1, 0, 4'd4, 32'h200, '0);
      exp_load_q.push_back(32'h1234);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checks++;
            if (wb_en_out !== 1'b0 || mem_r_en_out !== 1'b0 || data_mem_out !== '0) begin
               errors++;
               $display("FAIL drain_bubble%0d: wb=%b rd=%b data=%h, required 0 0 0",
                        i, wb_en_out, mem_r_en_out, data_mem_out);
            end
         end
         if (mem_req === 1'b1 && mem_we === 1'b1 && mem_ready === 1'b1) wr_done = i;
         if (mem_req === 1'b1 && mem_we === 1'b0 && rd_start < 0) begin
            rd_start = i;
            checks++;
            if (mem_addr !== 32'h200) begin
               errors++;
               $display("FAIL drain_rd_addr: addr=%h, required 00000200", mem_addr);
            end
         end
         if (freeze_out === 1'b0) begin
            done = 1'b1;
            break;
         end
         frozen++;
         step();
      end
      // 3 drain cycles + 1 IDLE gap + 2 non-final read cycles
      checks++;
      if (!done || frozen != 6) begin
         errors++;
         $display("FAIL drain_stall: frozen cycles=%0d done=%b, required 6", frozen, done);
      end
      checks++;
      if (wr_done < 0 || rd_start <= wr_done) begin
         errors++;
         $display("FAIL drain_order: write done at %0d read start at %0d, required write first",
                  wr_done, rd_start);
      end
      step();
      drive(0, 0, 0, '0, '0, '0);
      @(negedge clk);
      checks++;
      if (dest_out !== 4'd4) begin
         errors++;
         $display("FAIL drain_dest: dest=%h, required 4", dest_out);
      end
   endtask

   task automatic test_reset_mid_load();
      auto_en = 1'b0; manual_ready = 1'b0;
      step();
      drive(0, 0, 1, '0, 32'h600, 32'h77);
      step();
      drive(1, 1, 0, 4'd6, 32'h500, '0);
      @(negedge clk);
      checks++;
      if (freeze_out !== 1'b1) begin
         errors++;
         $display("FAIL rml_freeze: freeze=%b, required 1", freeze_out);
      end
      step();
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h500) begin
         errors++;
         $display("FAIL rml_req: req=%b we=%b addr=%h, required 1 0 00000500", mem_req, mem_we, mem_addr);
      end
      step();
      rst = 1'b1;
      drive(0, 0, 0, '0, '0, '0);
      step();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || sb_empty !== 1'b1 || freeze_out !== 1'b0) begin
         errors++;
         $display("FAIL rml_ctrl: req=%b sb_empty=%b freeze=%b, required 0 1 0", mem_req, sb_empty, freeze_out);
      end
      checks++;
      if ({wb_en_out, mem_r_en_out, dest_out, alu_res_out, data_mem_out} !== '0) begin
         errors++;
         $display("FAIL rml_outs: wb=%b rd=%b dest=%h res=%h data=%h, required all 0",
                  wb_en_out, mem_r_en_out, dest_out, alu_res_out, data_mem_out);
      end
      repeat (4) step();
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || sb_empty !== 1'b1) begin
         errors++;
         $display("FAIL rml_discard: req=%b sb_empty=%b, required 0 1", mem_req, sb_empty);
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_store_forward();
      test_youngest();
      test_buffer_full();
      test_back_to_back();
      test_load_miss_during_drain();
      test_reset_mid_load();
      checks++;
      if (exp_wr_q.size() != 0 || exp_load_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: writes pending=%0d loads pending=%0d, required 0 0",
                  exp_wr_q.size(), exp_load_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
